uart_frame_parser: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its byte strobe, received byte and stop-bit error flag.
- Assembles framed packets in the form SYNC, LEN, LEN payload bytes, CHK.
- Buffers the payload and validates length and checksum.
- Streams each good payload out on a valid/ready interface and reports every bad frame with an error code.

---
 rtl/uart_frame_parser.sv | 187 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART receiver: hunts SYNC, collects LEN payload bytes plus an
// XOR checksum, then streams good payloads on valid/ready and reports aborted frames.
module uart_frame_parser #(
   parameter logic [7:0] SYNC_BYTE    = 8'hAA,
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_CLKS = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_error,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       overrun,
   output logic       busy
);

   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int TO_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [1:0] ERR_CHK     = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_LINE    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_HUNT,
      S_GET_LEN,
      S_GET_DATA,
      S_GET_CHK,
      S_DRAIN
   } state_t;

   state_t          state_reg, state_next;
   logic [7:0]      len_reg, len_next;
   logic [7:0]      chk_reg, chk_next;
   logic [7:0]      wr_ptr_reg, wr_ptr_next;
   logic [7:0]      rd_ptr_reg, rd_ptr_next;
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic            frame_ok_reg, frame_ok_next;
   logic            frame_err_reg, frame_err_next;
   logic [1:0]      err_code_reg, err_code_next;
   logic            overrun_reg, overrun_next;
   logic            buf_we;
   logic            in_frame;
   logic            handshake;

   logic [7:0] buf_mem [DEPTH];

   // Payload store; contents need no reset because rd/wr pointers gate every use.
   always_ff @(posedge clk) begin
      if (buf_we && !rst) begin
         buf_mem[wr_ptr_reg[ADDR_W-1:0]] <= rx_byte;
      end
   end

   assign busy      = (state_reg != S_HUNT);
   assign out_valid = (state_reg == S_DRAIN);
   assign out_data  = buf_mem[rd_ptr_reg[ADDR_W-1:0]];
   assign out_last  = out_valid && (rd_ptr_reg == (len_reg - 8'd1));
   assign handshake = out_valid && out_ready;
   assign in_frame  = (state_reg == S_GET_LEN) || (state_reg == S_GET_DATA) ||
                      (state_reg == S_GET_CHK);

   assign frame_ok  = frame_ok_reg;
   assign frame_err = frame_err_reg;
   assign err_code  = err_code_reg;
   assign overrun   = overrun_reg;

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      chk_next       = chk_reg;
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      frame_ok_next  = 1'b0;
      frame_err_next = 1'b0;
      err_code_next  = err_code_reg;
      overrun_next   = 1'b0;
      buf_we         = 1'b0;
      // Idle gap counter: any strobe restarts it, and it only runs inside a frame.
      to_cnt_next    = (in_frame && !rx_valid && !rx_error) ? to_cnt_reg + TO_W'(1) : '0;

      unique case (state_reg)
         S_HUNT: begin
            if (rx_valid && rx_byte == SYNC_BYTE) begin
               state_next = S_GET_LEN;
            end
         end

         S_GET_LEN, S_GET_DATA, S_GET_CHK: begin
            if (rx_error) begin
               state_next     = S_HUNT;
               frame_err_next = 1'b1;
               err_code_next  = ERR_LINE;
            end else if (rx_valid) begin
               if (state_reg == S_GET_LEN) begin
                  if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                     state_next     = S_HUNT;
                     frame_err_next = 1'b1;
                     err_code_next  = ERR_LEN;
                  end else begin
                     len_next    = rx_byte;
                     chk_next    = rx_byte;
                     wr_ptr_next = 8'd0;
                     state_next  = S_GET_DATA;
                  end
               end else if (state_reg == S_GET_DATA) begin
                  buf_we      = 1'b1;
                  chk_next    = chk_reg ^ rx_byte;
                  wr_ptr_next = wr_ptr_reg + 8'd1;
                  if ((wr_ptr_reg + 8'd1) == len_reg) begin
                     state_next = S_GET_CHK;
                  end
               end else begin
                  if (rx_byte == chk_reg) begin
                     state_next    = S_DRAIN;
                     frame_ok_next = 1'b1;
                     rd_ptr_next   = 8'd0;
                  end else begin
                     state_next     = S_HUNT;
                     frame_err_next = 1'b1;
                     err_code_next  = ERR_CHK;
                  end
               end
            end else if (to_cnt_reg == TO_LAST) begin
               state_next     = S_HUNT;
               frame_err_next = 1'b1;
               err_code_next  = ERR_TIMEOUT;
               to_cnt_next    = '0;
            end
         end

         S_DRAIN: begin
            // Receiver keeps running while we drain; those bytes are lost, SYNC included.
            overrun_next = rx_valid;
            if (handshake) begin
               rd_ptr_next = rd_ptr_reg + 8'd1;
               if (out_last) begin
                  state_next = S_HUNT;
               end
            end
         end

         default: begin
            state_next = S_HUNT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_HUNT;
         len_reg       <= 8'd0;
         chk_reg       <= 8'd0;
         wr_ptr_reg    <= 8'd0;
         rd_ptr_reg    <= 8'd0;
         to_cnt_reg    <= '0;
         frame_ok_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         err_code_reg  <= 2'd0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         chk_reg       <= chk_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         to_cnt_reg    <= to_cnt_next;
         frame_ok_reg  <= frame_ok_next;
         frame_err_reg <= frame_err_next;
         err_code_reg  <= err_code_next;
         overrun_reg   <= overrun_next;
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: table of frames, directed corner cases
// and randomized frames scored against a rule-level reference model.
module tb_uart_frame_parser;

   localparam int MAX_LEN = 16;
   localparam int TO      = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_byte = 8'd0;
   logic       rx_valid = 1'b0;
   logic       rx_error = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overrun;
   logic       busy;

   always #5 clk = ~clk;

   uart_frame_parser #(
      .SYNC_BYTE   (8'hAA),
      .MAX_LEN     (MAX_LEN),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_error (rx_error),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .frame_ok (frame_ok),
      .frame_err(frame_err),
      .err_code (err_code),
      .overrun  (overrun),
      .busy     (busy)
   );

   int checks = 0;
   int errors = 0;

   // Observed events, gathered on the falling edge.
   logic [7:0] beat_data[$];
   bit         beat_last[$];
   int         err_q[$];
   int         ok_cnt = 0;
   int         ovr_cnt = 0;
   int         stable_viol = 0;
   int         dbl_pulse = 0;
   bit         prev_stall = 0, prev_rst = 0, prev_ok = 0, prev_err = 0, prev_last = 0;
   logic [7:0] prev_data = 8'd0;
   bit         rand_ready = 0;

   logic [7:0] exp_pl[$];
   logic [7:0] r_pl [0:19];

   always @(negedge clk) begin
      if (out_valid && out_ready && !rst) begin
         beat_data.push_back(out_data);
         beat_last.push_back(out_last);
      end
      if (frame_ok) ok_cnt++;
      if (frame_err) err_q.push_back(int'(err_code));
      if (overrun) ovr_cnt++;
      if (prev_stall && !prev_rst &&
          (!out_valid || out_data != prev_data || out_last != prev_last)) stable_viol++;
      if ((frame_ok && prev_ok) || (frame_err && prev_err)) dbl_pulse++;
      prev_stall = out_valid && !out_ready;
      prev_rst   = rst;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_ok    = frame_ok;
      prev_err   = frame_err;
   end

   always @(posedge clk) begin
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_err();
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
   endtask

   task automatic send_packed(input int n, input logic [63:0] bytes);
      for (int i = 0; i < n; i++) send_byte(bytes[63-8*i -: 8]);
   endtask

   task automatic clear_obs();
      beat_data.delete();
      beat_last.delete();
      err_q.delete();
      ok_cnt  = 0;
      ovr_cnt = 0;
   endtask

   task automatic settle();
      int n = 0;
      while (busy && n < 600) begin
         tick();
         n++;
      end
      check("idle", int'(busy), 0);
      tick();
      tick();
   endtask

   task automatic check_outcome(input string tag, input int exp_ok, input int exp_code,
                                input int exp_ovr);
      check({tag, " frame_ok"}, ok_cnt, exp_ok);
      check({tag, " frame_err"}, err_q.size(), exp_ok ? 0 : 1);
      if (!exp_ok && err_q.size() > 0) check({tag, " err_code"}, err_q[0], exp_code);
      check({tag, " overrun"}, ovr_cnt, exp_ovr);
      check({tag, " beats"}, beat_data.size(), exp_pl.size());
      for (int i = 0; i < exp_pl.size() && i < beat_data.size(); i++) begin
         check({tag, " out_data"}, int'(beat_data[i]), int'(exp_pl[i]));
         check({tag, " out_last"}, int'(beat_last[i]), (i == exp_pl.size() - 1) ? 1 : 0);
      end
      $display("frame %s: ok=%0d errs=%0d beats=%0d overruns=%0d", tag, ok_cnt,
               err_q.size(), beat_data.size(), ovr_cnt);
      clear_obs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " out_valid"}, int'(out_valid), 0);
      check({tag, " out_last"}, int'(out_last), 0);
      check({tag, " frame_ok"}, int'(frame_ok), 0);
      check({tag, " frame_err"}, int'(frame_err), 0);
      check({tag, " err_code"}, int'(err_code), 0);
      check({tag, " overrun"}, int'(overrun), 0);
      check({tag, " busy"}, int'(busy), 0);
   endtask

   // Reference: apply the frame rules position by position. errpos is where an
   // rx_error replaces a byte (0 = none). Returns 1 for a good frame.
   function automatic int model_frame(input int len, input int errpos,
                                      input logic [7:0] chk, output int code);
      logic [7:0] x;
      code = 0;
      if (errpos == 1) begin code = 2; return 0; end
      if (len == 0 || len > MAX_LEN) begin code = 1; return 0; end
      for (int p = 2; p <= len + 2; p++) begin
         if (errpos == p) begin code = 2; return 0; end
      end
      x = 8'(len);
      for (int i = 0; i < len; i++) x = x ^ r_pl[i];
      if (chk != x) begin code = 0; return 0; end
      return 1;
   endfunction

   typedef struct {
      int          n;
      logic [63:0] bytes;
      int          exp_ok;
      int          exp_code;
      int          pl_start;
      int          pl_n;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [63:0] row;
      logic [7:0]  chk;
      logic [7:0]  pl3 [0:2];
      int          k;

      tbl[0] = '{5, 64'hAA02_1122_3100_0000, 1, 0, 2, 2};
      tbl[1] = '{5, 64'hAA02_1122_3000_0000, 0, 0, 0, 0};
      tbl[2] = '{4, 64'hAA01_5A5B_0000_0000, 1, 0, 2, 1};
      tbl[3] = '{2, 64'hAA00_0000_0000_0000, 0, 1, 0, 0};
      tbl[4] = '{2, 64'hAA11_0000_0000_0000, 0, 1, 0, 0};
      tbl[5] = '{5, 64'h13AA_0107_0600_0000, 1, 0, 3, 1};
      tbl[6] = '{6, 64'hAA03_AAAA_0102_0000, 1, 0, 2, 3};

      // Reset state
      tick(); tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      clear_obs();

      // Table-driven frames
      for (int t = 0; t < 7; t++) begin
         row = tbl[t].bytes;
         exp_pl.delete();
         if (tbl[t].exp_ok != 0)
            for (int i = 0; i < tbl[t].pl_n; i++)
               exp_pl.push_back(row[63-8*(tbl[t].pl_start+i) -: 8]);
         send_packed(tbl[t].n, row);
         settle();
         check_outcome($sformatf("vec%0d", t), tbl[t].exp_ok, tbl[t].exp_code, 0);
      end

      // Maximum length frame
      exp_pl.delete();
      chk = 8'h10;
      for (int i = 0; i < 16; i++) begin
         exp_pl.push_back(8'(i * 7 + 3));
         chk = chk ^ 8'(i * 7 + 3);
      end
      send_byte(8'hAA);
      send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(exp_pl[i]);
      send_byte(chk);
      settle();
      check_outcome("maxlen", 1, 0, 0);

      // Line error mid-frame
      exp_pl.delete();
      send_packed(3, 64'hAA03_1100_0000_0000);
      send_err();
      settle();
      check_outcome("line_err", 0, 2, 0);

      // Timeout measured from the last data strobe
      send_packed(3, 64'hAA03_1100_0000_0000);
      k = 0;
      for (int i = 1; i <= TO + 20; i++) begin
         tick();
         if (frame_err) begin k = i; break; end
      end
      check("timeout cycles", k, TO);
      settle();
      check_outcome("timeout", 0, 3, 0);

      // Backpressure plus an overrun SYNC byte during drain
      pl3[0] = 8'hC1; pl3[1] = 8'h5A; pl3[2] = 8'h07;
      exp_pl.delete();
      chk = 8'h03;
      for (int i = 0; i < 3; i++) begin
         exp_pl.push_back(pl3[i]);
         chk = chk ^ pl3[i];
      end
      out_ready = 1'b0;
      send_byte(8'hAA);
      send_byte(8'h03);
      for (int i = 0; i < 3; i++) send_byte(pl3[i]);
      send_byte(chk);
      repeat (20) tick();
      send_byte(8'hAA);
      repeat (30) tick();
      out_ready = 1'b1;
      settle();
      check_outcome("overrun", 1, 0, 1);

      // Reset during GET_DATA
      send_packed(4, 64'hAA05_0102_0000_0000);
      rst = 1'b1;
      tick();
      check_all_zero("rst_data");
      rst = 1'b0;
      tick(); tick();
      check("rst_data no err", err_q.size(), 0);
      clear_obs();

      // Reset during DRAIN
      out_ready = 1'b0;
      send_packed(5, 64'hAA02_1122_3100_0000);
      repeat (3) tick();
      check("drain valid", int'(out_valid), 1);
      rst = 1'b1;
      tick();
      check_all_zero("rst_drain");
      rst = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      check("rst_drain no err", err_q.size(), 0);
      check("rst_drain no beats", beat_data.size(), 0);
      clear_obs();

      exp_pl.delete();
      exp_pl.push_back(8'h11);
      exp_pl.push_back(8'h22);
      send_packed(5, 64'hAA02_1122_3100_0000);
      settle();
      check_outcome("post_rst", 1, 0, 0);

      // Randomized frames against the reference model
      rand_ready = 1;
      for (int f = 0; f < 40; f++) begin
         int         len, errpos, code, ok, nj;
         logic [7:0] b, rchk, x;
         nj = $urandom_range(0, 2);
         for (int j = 0; j < nj; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hAA) b = 8'h55;
            send_byte(b);
            if ($urandom_range(0, 3) == 0) send_err();
         end
         len = $urandom_range(0, 18);
         for (int i = 0; i < 20; i++) r_pl[i] = 8'($urandom_range(0, 255));
         x = 8'(len);
         for (int i = 0; i < len && i < 20; i++) x = x ^ r_pl[i];
         rchk = ($urandom_range(0, 3) != 0) ? x : 8'($urandom_range(0, 255));
         errpos = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len + 2) : 0;

         ok = model_frame(len, errpos, rchk, code);
         exp_pl.delete();
         if (ok != 0) for (int i = 0; i < len; i++) exp_pl.push_back(r_pl[i]);

         send_byte(8'hAA);
         for (int pos = 1; ; pos++) begin
            repeat ($urandom_range(0, 3)) tick();
            if (pos == errpos) begin send_err(); break; end
            if (pos == 1) b = 8'(len);
            else if (pos <= len + 1) b = r_pl[pos-2];
            else b = rchk;
            send_byte(b);
            if (pos == 1 && (len == 0 || len > MAX_LEN)) break;
            if (pos == len + 2) break;
         end
         settle();
         check_outcome($sformatf("rand%0d", f), ok, code, 0);
      end
      rand_ready = 0;
      out_ready  = 1'b1;

      check("stable under stall", stable_viol, 0);
      check("no double pulses", dbl_pulse, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
